// File: rtl/shmem_pkg.sv
// Shared widths, FSM encoding and address helpers for the shared-memory requester.
package shmem_pkg;

  localparam int ADDR_W  = 12;
  localparam int BANK_W  = 4;
  localparam int OFF_W   = 8;
  localparam int DATA_W  = 8;
  localparam int N_BANKS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Bank number sits directly above the in-bank offset.
  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W +: BANK_W];
  endfunction

endpackage

// File: rtl/shmem_req_timer.sv
// WAIT-phase cycle counter; expired is high during the last allowed WAIT cycle.
module shmem_req_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // The edge that would bring the count to TIMEOUT_CYCLES ends the wait.
  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/shmem_requester.sv
// Single-outstanding requester from one core to 16 banked shared-memory arbiters.
// Define SHMEM_REQ_TIMEOUT_EN to abandon requests after TIMEOUT_CYCLES in WAIT.
module shmem_requester
  import shmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      req_ready,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [N_BANKS-1:0]        mem_finish,
  input  logic [N_BANKS*DATA_W-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | ready, nothing presented to the arbiters
  // WAIT  | latched request presented until target bank finishes
  // RESP  | one-cycle completion pulse, then back to IDLE

  state_t            state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [BANK_W-1:0] bank;
  logic              bank_hit;
  logic [DATA_W-1:0] bank_data;
  logic              accept;
  logic              complete;
  logic              timed_out;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign bank     = bank_of(addr_q);
  assign bank_hit = mem_finish[bank];

  always_comb begin
    bank_data = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (bank == BANK_W'(b)) bank_data = mem_rdata[b*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bank_hit) begin
          complete = 1'b1;
          state_d  = ST_RESP;
        end else if (timed_out) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (complete)       rdata_q <= we_q ? '0 : bank_data;
      else if (timed_out) rdata_q <= '0;
    end
  end

`ifdef SHMEM_REQ_TIMEOUT_EN
  logic tmr_expired;
  logic err_q;

  shmem_req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != ST_WAIT),
    .enable (state_q == ST_WAIT),
    .expired(tmr_expired)
  );

  // A target finish on the expiry edge still counts as a normal completion.
  assign timed_out = tmr_expired & ~bank_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          err_q <= 1'b0;
    else if (complete)  err_q <= 1'b0;
    else if (timed_out) err_q <= 1'b1;
  end

  assign resp_err = err_q;
`else
  assign timed_out = 1'b0;
  assign resp_err  = 1'b0;
`endif

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign mem_read   = (state_q == ST_WAIT) & ~we_q;
  assign mem_write  = (state_q == ST_WAIT) &  we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_shmem_requester.sv
// Randomized self-checking bench for shmem_requester against a transaction-level model.
module tb_shmem_requester;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_we = 1'b0;
  logic [11:0]  req_addr = '0;
  logic [7:0]   req_wdata = '0;
  logic         req_ready;
  logic         resp_valid;
  logic [7:0]   resp_rdata;
  logic         resp_err;
  logic         mem_read;
  logic         mem_write;
  logic [11:0]  mem_addr;
  logic [7:0]   mem_wdata;
  logic [15:0]  mem_finish = '0;
  logic [127:0] mem_rdata;
  logic [7:0]   bank_bytes [16];

  int checks = 0;
  int failures = 0;

  // observations from the last run_txn, plus the model's expected read byte
  int       o_rd, o_wr, o_addr_err, o_wdata_err, o_early_resp;
  logic     o_resp1, o_resp2, o_err, o_ready_before, o_ready_after, o_busy_in_resp, o_hold_ok;
  logic [7:0] o_rdata, m_rdata;

  shmem_requester #(.TIMEOUT_CYCLES(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_finish(mem_finish),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  always_comb begin
    mem_rdata = '0;
    for (int b = 0; b < 16; b++) mem_rdata[b*8 +: 8] = bank_bytes[b];
  end

  task automatic shuffle_bytes();
    for (int b = 0; b < 16; b++) bank_bytes[b] = 8'($urandom);
  endtask

  // Drives one request whose target finish arrives in WAIT cycle d; other banks see 'noise'.
  task automatic run_txn(input logic we, input logic [11:0] addr, input logic [7:0] wdata,
                         input int d, input logic [15:0] noise, input int fbyte);
    int bank;
    logic [15:0] tbit;
    bank = int'(addr[11:8]);
    tbit = 16'(1) << bank;
    o_rd = 0; o_wr = 0; o_addr_err = 0; o_wdata_err = 0; o_early_resp = 0;
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    mem_finish = noise;
    o_ready_before = req_ready;
    @(negedge clock);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 12'($urandom); req_wdata = 8'($urandom);
    for (int k = 1; k <= d; k++) begin
      if (mem_read) o_rd++;
      if (mem_write) o_wr++;
      if (mem_addr !== addr) o_addr_err++;
      if (we && mem_wdata !== wdata) o_wdata_err++;
      if (resp_valid) o_early_resp++;
      shuffle_bytes();
      if (k == d) begin
        if (fbyte >= 0) bank_bytes[bank] = 8'(fbyte);
        m_rdata = we ? 8'h00 : bank_bytes[bank];
        mem_finish = noise | tbit;
      end else begin
        mem_finish = noise & ~tbit;
      end
      if (k < d) @(negedge clock);
    end
    @(negedge clock);
    o_resp1 = resp_valid; o_rdata = resp_rdata; o_err = resp_err;
    o_busy_in_resp = mem_read | mem_write;
    mem_finish = '1;
    shuffle_bytes();
    @(negedge clock);
    o_resp2 = resp_valid; o_ready_after = req_ready; o_hold_ok = (resp_rdata === o_rdata);
    mem_finish = '0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL rst_mem_read got=%0b exp=0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rst_mem_write got=%0b exp=0", mem_write); end
    checks++; if (mem_addr !== 12'h000) begin failures++; $display("FAIL rst_mem_addr got=%h exp=000", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=00", mem_wdata); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%0b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 8'h00) begin failures++; $display("FAIL rst_resp_rdata got=%h exp=00", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp_err got=%0b exp=0", resp_err); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%0b exp=1", req_ready); end
  endtask

  task automatic test_read();
    run_txn(1'b0, 12'h3A5, 8'h00, 4, 16'h0000, 'h5C);
    checks++; if (o_ready_before !== 1'b1) begin failures++; $display("FAIL rd_ready got=%0b exp=1", o_ready_before); end
    checks++; if (o_rd != 4) begin failures++; $display("FAIL rd_mem_read_cycles got=%0d exp=4", o_rd); end
    checks++; if (o_wr != 0) begin failures++; $display("FAIL rd_mem_write_cycles got=%0d exp=0", o_wr); end
    checks++; if (o_addr_err != 0) begin failures++; $display("FAIL rd_mem_addr bad_cycles=%0d exp=0", o_addr_err); end
    checks++; if (o_resp1 !== 1'b1 || o_resp2 !== 1'b0) begin failures++; $display("FAIL rd_resp_pulse got=%0b%0b exp=10", o_resp1, o_resp2); end
    checks++; if (o_rdata !== 8'h5C) begin failures++; $display("FAIL rd_rdata got=%h exp=5c", o_rdata); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL rd_err got=%0b exp=0", o_err); end
    checks++; if (o_busy_in_resp !== 1'b0) begin failures++; $display("FAIL rd_mem_idle_in_resp got=%0b exp=0", o_busy_in_resp); end
    checks++; if (o_hold_ok !== 1'b1) begin failures++; $display("FAIL rd_rdata_hold got=%h exp=5c", resp_rdata); end
  endtask

  task automatic test_write();
    run_txn(1'b1, 12'hF00, 8'h77, 3, 16'h0000, -1);
    checks++; if (o_wr != 3) begin failures++; $display("FAIL wr_mem_write_cycles got=%0d exp=3", o_wr); end
    checks++; if (o_rd != 0) begin failures++; $display("FAIL wr_mem_read_cycles got=%0d exp=0", o_rd); end
    checks++; if (o_wdata_err != 0) begin failures++; $display("FAIL wr_mem_wdata bad_cycles=%0d exp=0", o_wdata_err); end
    checks++; if (o_resp1 !== 1'b1) begin failures++; $display("FAIL wr_resp_valid got=%0b exp=1", o_resp1); end
    checks++; if (o_rdata !== 8'h00) begin failures++; $display("FAIL wr_rdata got=%h exp=00", o_rdata); end
  endtask

  task automatic test_wrong_bank();
    run_txn(1'b0, {4'h2, 8'($urandom)}, 8'h00, 3, 16'h0020, -1);
    checks++; if (o_early_resp != 0) begin failures++; $display("FAIL wb_early_resp got=%0d exp=0", o_early_resp); end
    checks++; if (o_rd != 3) begin failures++; $display("FAIL wb_mem_read_cycles got=%0d exp=3", o_rd); end
    checks++; if (o_resp1 !== 1'b1) begin failures++; $display("FAIL wb_resp_valid got=%0b exp=1", o_resp1); end
    checks++; if (o_rdata !== m_rdata) begin failures++; $display("FAIL wb_rdata got=%h exp=%h", o_rdata, m_rdata); end
  endtask

  task automatic test_min_latency();
    logic we;
    we = 1'($urandom);
    run_txn(we, 12'($urandom), 8'($urandom), 1, 16'h0000, -1);
    checks++; if (o_resp1 !== 1'b1) begin failures++; $display("FAIL lat_resp_valid got=%0b exp=1", o_resp1); end
    checks++; if (o_rd + o_wr != 1) begin failures++; $display("FAIL lat_access_cycles got=%0d exp=1", o_rd + o_wr); end
    checks++; if (o_rdata !== m_rdata) begin failures++; $display("FAIL lat_rdata got=%h exp=%h", o_rdata, m_rdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic we;
      int d;
      we = 1'($urandom);
      d = $urandom_range(1, 6);
      run_txn(we, 12'($urandom), 8'($urandom), d, 16'($urandom), -1);
      checks++; if (o_rd != (we ? 0 : d) || o_wr != (we ? d : 0)) begin failures++; $display("FAIL rnd%0d_access rd=%0d wr=%0d exp_cycles=%0d we=%0b", i, o_rd, o_wr, d, we); end
      checks++; if (o_addr_err != 0 || o_wdata_err != 0 || o_early_resp != 0) begin failures++; $display("FAIL rnd%0d_wait addr_bad=%0d wdata_bad=%0d early=%0d exp=0", i, o_addr_err, o_wdata_err, o_early_resp); end
      checks++; if (o_resp1 !== 1'b1 || o_resp2 !== 1'b0 || o_err !== 1'b0) begin failures++; $display("FAIL rnd%0d_resp got=%0b%0b err=%0b exp=10 err=0", i, o_resp1, o_resp2, o_err); end
      checks++; if (o_rdata !== m_rdata) begin failures++; $display("FAIL rnd%0d_rdata got=%h exp=%h", i, o_rdata, m_rdata); end
      checks++; if (o_hold_ok !== 1'b1 || o_ready_after !== 1'b1) begin failures++; $display("FAIL rnd%0d_after hold=%0b ready=%0b exp=11", i, o_hold_ok, o_ready_after); end
    end
  endtask

  task automatic test_busy();
    int ready_bad;
    int addr_bad;
    ready_bad = 0; addr_bad = 0;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h140; req_wdata = 8'h00;
    @(negedge clock);
    req_we = 1'b1; req_addr = 12'h611; req_wdata = 8'hA5;
    for (int k = 1; k <= 3; k++) begin
      if (req_ready !== 1'b0) ready_bad++;
      if (mem_addr !== 12'h140) addr_bad++;
      mem_finish = (k == 3) ? 16'h0002 : 16'h0000;
      if (k < 3) @(negedge clock);
    end
    checks++; if (ready_bad != 0) begin failures++; $display("FAIL busy_ready_in_wait bad_cycles=%0d exp=0", ready_bad); end
    checks++; if (addr_bad != 0) begin failures++; $display("FAIL busy_addr_stable bad_cycles=%0d exp=0", addr_bad); end
    @(negedge clock);
    mem_finish = '0;
    checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL busy_resp got valid=%0b ready=%0b exp valid=1 ready=0", resp_valid, req_ready); end
    @(negedge clock);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL busy_idle got ready=%0b valid=%0b wr=%0b exp 1 0 0", req_ready, resp_valid, mem_write); end
    @(negedge clock);
    checks++; if (mem_write !== 1'b1 || mem_addr !== 12'h611 || mem_wdata !== 8'hA5) begin failures++; $display("FAIL busy_second got wr=%0b addr=%h wdata=%h exp 1 611 a5", mem_write, mem_addr, mem_wdata); end
    req_valid = 1'b0;
    mem_finish = 16'h0040;
    @(negedge clock);
    mem_finish = '0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 8'h00) begin failures++; $display("FAIL busy_second_resp got valid=%0b rdata=%h exp 1 00", resp_valid, resp_rdata); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_wait();
    int resp_seen;
    int ready_bad;
    resp_seen = 0; ready_bad = 0;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h722;
    @(negedge clock);
    req_valid = 1'b0;
    checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL rmw_read_before got=%0b exp=1", mem_read); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_read !== 1'b0 || mem_addr !== 12'h000) begin failures++; $display("FAIL rmw_async_clear got rd=%0b addr=%h exp 0 000", mem_read, mem_addr); end
    mem_finish = 16'h0080;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (resp_valid) resp_seen++;
      if (!req_ready) ready_bad++;
    end
    mem_finish = '0;
    checks++; if (resp_seen != 0) begin failures++; $display("FAIL rmw_no_resp got=%0d exp=0", resp_seen); end
    checks++; if (ready_bad != 0) begin failures++; $display("FAIL rmw_ready_after bad_cycles=%0d exp=0", ready_bad); end
  endtask

`ifdef SHMEM_REQ_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    logic got;
    n = 0; got = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h933;
    @(negedge clock);
    req_valid = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      if (resp_valid) got = 1'b1;
      else begin
        if (mem_read) n++;
        @(negedge clock);
      end
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL to_resp_seen got=%0b exp=1", got); end
    checks++; if (n != 8) begin failures++; $display("FAIL to_wait_cycles got=%0d exp=8", n); end
    checks++; if (resp_err !== 1'b1 || resp_rdata !== 8'h00 || mem_read !== 1'b0) begin failures++; $display("FAIL to_resp got err=%0b rdata=%h rd=%0b exp 1 00 0", resp_err, resp_rdata, mem_read); end
    @(negedge clock);
    run_txn(1'b0, 12'h4C0, 8'h00, 8, 16'h0000, 'hC3);
    checks++; if (o_err !== 1'b0 || o_rdata !== 8'hC3) begin failures++; $display("FAIL to_finish_wins got err=%0b rdata=%h exp 0 c3", o_err, o_rdata); end
    checks++; if (o_rd != 8 || o_resp1 !== 1'b1) begin failures++; $display("FAIL to_finish_wins_timing got rd=%0d valid=%0b exp 8 1", o_rd, o_resp1); end
  endtask
`else
  task automatic test_no_timeout();
    run_txn(1'b0, {4'hB, 8'($urandom)}, 8'h00, 40, 16'h0000, -1);
    checks++; if (o_rd != 40 || o_early_resp != 0) begin failures++; $display("FAIL nt_wait got rd=%0d early=%0d exp 40 0", o_rd, o_early_resp); end
    checks++; if (o_resp1 !== 1'b1 || o_err !== 1'b0) begin failures++; $display("FAIL nt_resp got valid=%0b err=%0b exp 1 0", o_resp1, o_err); end
    checks++; if (o_rdata !== m_rdata) begin failures++; $display("FAIL nt_rdata got=%h exp=%h", o_rdata, m_rdata); end
  endtask
`endif

  initial begin
    shuffle_bytes();
    test_reset();
    test_read();
    test_write();
    test_wrong_bank();
    test_min_latency();
    test_busy();
    test_random();
    test_reset_mid_wait();
`ifdef SHMEM_REQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/shmem_requester.md
SHMEM_REQUESTER -- requirements
Module: shmem_requester

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles in WAIT before a request is abandoned (used only with SHMEM_REQ_TIMEOUT_EN).
REQ-002 SHALL have port clock  in  1  single clock; all state updates on its posedge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  1  core requests an access.
REQ-005 SHALL have port req_we  in  1  1 = write, 0 = read.
REQ-006 SHALL have port req_addr  in  12  [11:8] bank number, [7:0] offset inside the bank.
REQ-007 SHALL have port req_wdata  in  8  write data.
REQ-008 SHALL have port req_ready  out  1  requester can accept a request.
REQ-009 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata  out  8  read data; 0 for writes and errors.
REQ-011 SHALL have port resp_err  out  1  request timed out; valid with resp_valid.
REQ-012 SHALL have port mem_read  out  1  this core's read bit to all 16 bank arbiters.
REQ-013 SHALL have port mem_write  out  1  this core's write bit to all 16 bank arbiters.
REQ-014 SHALL have port mem_addr  out  12  address to the arbiters.
REQ-015 SHALL have port mem_wdata  out  8  write data to the arbiters.
REQ-016 SHALL have port mem_finish  in  16  bit b = this core's finish bit from bank arbiter b.
REQ-017 SHALL have port mem_rdata  in  128  bits [8b+7:8b] = this core's data slice from bank arbiter b.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-019 SHALL drive req_ready=1 only in IDLE; accept a request on the posedge where req_valid & req_ready, latching req_we, req_addr and req_wdata, and entering WAIT.
REQ-020 SHALL, in WAIT, hold mem_read=!we and mem_write=we with stable mem_addr/mem_wdata every cycle until completion; both SHALL be 0 outside WAIT.
REQ-021 SHALL complete when mem_finish[bank] is sampled 1 in WAIT (bank = latched addr[11:8]); on that edge capture mem_rdata[8*bank+7:8*bank] into resp_rdata for reads and 0 for writes, and enter RESP.
REQ-022 SHALL ignore mem_finish bits of other banks in every state, and all mem_finish bits in IDLE and RESP.
REQ-023 SHALL assert resp_valid for exactly the one cycle in RESP, then return to IDLE; minimum accept-to-resp_valid latency is 2 cycles; back-to-back requests are separated by at least one IDLE cycle.
REQ-024 SHALL hold resp_rdata stable from RESP until the next completion.
REQ-025 SHALL keep req_valid while not ready without effect; no queuing.

Reset
REQ-026 SHALL, on reset assertion, immediately (asynchronously) enter IDLE with mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0, timer=0; req_ready=1 after deassertion.
REQ-027 SHALL drop an in-flight request on reset without a response.

Configuration
REQ-028 SHALL, with SHMEM_REQ_TIMEOUT_EN defined, count WAIT cycles from 0; on count reaching TIMEOUT_CYCLES with no target finish, drop mem_read/mem_write, enter RESP with resp_err=1, resp_rdata=0; a target finish on that same edge wins (normal completion, resp_err=0).
REQ-029 SHALL, without SHMEM_REQ_TIMEOUT_EN, contain no timer, tie resp_err to 0 and wait in WAIT indefinitely.

Structure
REQ-030 SHALL take ADDR_W=12, BANK_W=4, OFF_W=8, DATA_W=8, N_BANKS=16 and the state encoding from shared package shmem_pkg.
REQ-031 SHALL place the timeout counter in sub-module shmem_req_timer (clear, enable, expired outputs), instantiated only under SHMEM_REQ_TIMEOUT_EN.

Verification
REQ-032 SHALL verify read: req addr 0x3A5, mem_finish[3] after 4 WAIT cycles, mem_rdata[31:24]=0x5C -> mem_read high 4 cycles, mem_addr=0x3A5, resp_valid one cycle, resp_rdata=0x5C, resp_err=0.
REQ-033 SHALL verify write: addr 0xF00, wdata 0x77, finish[15] -> mem_write high, mem_wdata=0x77, resp_rdata=0.
REQ-034 SHALL verify wrong bank: target bank 2, pulse mem_finish[5] then mem_finish[2] -> completion only on bit 2.
REQ-035 SHALL verify busy: req_valid held high through WAIT -> second request accepted only in the IDLE cycle after resp_valid.
REQ-036 SHALL verify reset mid-WAIT -> mem_read falls to 0 within the reset cycle, no resp_valid, req_ready=1 after release.
REQ-037 SHALL verify timeout (macro on, TIMEOUT_CYCLES=8, no finish) -> resp_valid with resp_err=1 exactly 8 WAIT cycles after entering WAIT.
